ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset)
//  to the keyboard over the shared open-drain ps2_clk/ps2_data lines and reports the device ACK.
//  It is the counterpart to the keyboard receive path, and sits beside it at the top level.
//  rx_inhibit tells the receive path to discard bus activity while a frame is in flight.
// PARAMETERS
//  INHIBIT_CYCLES  10000      clk cycles ps2_clk is held low before request-to-send (100 us @ 100 MHz)
//  TIMEOUT_CYCLES  2000000    max clk cycles from clock release to frame end (20 ms @ 100 MHz)
//  FILTER_CYCLES   4          cycles synchronized ps2_clk must be stable before the filtered level changes
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  tx_data      in   8  command byte; sampled on accept
//  tx_valid     in   1  request; accepted when tx_valid & tx_ready
//  tx_ready     out  1  1 only in IDLE
//  ps2_clk_in   in   1  PS/2 clock line level (asynchronous)
//  ps2_data_in  in   1  PS/2 data line level (asynchronous)
//  ps2_clk_oe   out  1  1 = drive PS/2 clock low; 0 = release (pull-up)
//  ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release
//  busy         out  1  state != IDLE
//  rx_inhibit   out  1  equals busy
//  done         out  1  one-cycle pulse at frame end (success, NACK or timeout)
//  ack_ok       out  1  device ACK seen; valid from done, held until next accept
//  timeout      out  1  frame aborted by timeout; valid from done, held until next accept
// BEHAVIOUR
//  Reset (async): state IDLE. ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_ok=0, timeout=0, busy=0, tx_ready=1.
//   Filtered clock resets to 1. Reset mid-frame releases both lines immediately.
//  Input path: 2-FF sync on both ps2 inputs. Filtered clk takes the synced value after FILTER_CYCLES
//   consecutive equal samples. fall = filtered clock 1->0 (one-cycle strobe).
//  Accept: latch tx_data and par = ~^tx_data (odd parity); clear ack_ok and timeout.
//   tx_valid outside IDLE is ignored (no queue).
//  FSM:
//   IDLE    -> INHIBIT on accept.
//   INHIBIT clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles -> RTS.
//   RTS     clk_oe=1, data_oe=1 (start bit) for exactly 8 cycles -> SEND; timeout counter cleared.
//   SEND    clk_oe=0. bit_idx 0..10 counts falls, and data_oe changes only on the cycle after a fall:
//           falls 1-8 -> data_oe=~tx_data[fall-1] (LSB first)
//           fall 9 -> data_oe=~par
//           fall 10 -> data_oe=0 (stop bit/release)
//           fall 11 -> ack_ok = ~synced ps2_data_in -> WAIT_IDLE
//   WAIT_IDLE both lines released; wait for filtered clk=1 and synced data=1 -> DONE.
//   DONE    done=1 for one cycle -> IDLE.
//  Timeout: counter runs in SEND and WAIT_IDLE.
//   On reaching TIMEOUT_CYCLES: clk_oe=0, data_oe=0, timeout=1, ack_ok=0 -> DONE.
//  NACK (data high at fall 11): frame completes normally with ack_ok=0, timeout=0.
//  Timeout and fall 11 in the same cycle: timeout wins.
//  Latency: accept -> start bit = INHIBIT_CYCLES+1 cycles. Counters are sized by $clog2 of their parameter.
// TESTING
//  1 tx 0xED, device model clocks ~12.5 kHz and ACKs -> bus bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
//    Checks: done pulse, ack_ok=1, timeout=0.
//  2 tx 0xF4, device leaves data high at fall 11 -> parity bit 0 on bus; done, ack_ok=0, timeout=0.
//  3 tx 0x00 (parity 1), device never clocks -> after TIMEOUT_CYCLES in SEND: both oe=0, done, timeout=1.
//  4 FILTER_CYCLES=4: inject 2-cycle low glitch on ps2_clk_in mid-frame -> bit_idx unchanged, frame still correct.
//  5 assert rst_n=0 after fall 4 of 0xFF -> clk_oe=data_oe=0 same cycle; after release tx_ready=1.
//    Next 0xFF frame is correct.
//  6 timing: clk_oe high exactly INHIBIT_CYCLES+8 cycles, data_oe rises at RTS entry.
//    tx_valid pulses while busy -> ignored.

Source files
------------

// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: command handshake, open-drain line controls and frame status.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic       ack_ok;
    logic       timeout;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, ack_ok, timeout
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, ack_ok, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one odd-parity byte
// on device-generated clock falls, collect the ACK, with a frame timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_CYCLES  = 4
) (
    input logic          clk,
    input logic          rst_n,
    ps2_host_tx_if.slave bus
);
    localparam int INH_W = ($clog2(INHIBIT_CYCLES) > 3) ? $clog2(INHIBIT_CYCLES) : 3;
    localparam int TO_W  = ($clog2(TIMEOUT_CYCLES) > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FLT_W = ($clog2(FILTER_CYCLES) > 1) ? $clog2(FILTER_CYCLES) : 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] RTS_LAST = INH_W'(7);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_IDLE, S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;
    logic               r_clk_filt, r_clk_filt_d;
    logic [FLT_W-1:0]   r_flt_cnt;
    logic [INH_W-1:0]   r_phase_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [3:0]         r_bit_idx;
    logic [7:0]         r_byte;
    logic               r_par, r_data_bit, r_ack, r_to;
    logic               w_fall, w_accept, w_inh_end, w_rts_end, w_to_hit, w_last_fall, w_line_idle;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= bus.ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= bus.ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    // Filtered clock follows the synced level only after FILTER_CYCLES differing samples in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_flt_cnt    <= '0;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_LAST) begin
                r_clk_filt <= r_clk_sync;
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_fall      = r_clk_filt_d & ~r_clk_filt;
    assign w_accept    = (r_state == S_IDLE) & bus.tx_valid;
    assign w_inh_end   = (r_state == S_INHIBIT) && (r_phase_cnt == INH_LAST);
    assign w_rts_end   = (r_state == S_RTS) && (r_phase_cnt == RTS_LAST);
    assign w_to_hit    = ((r_state == S_SEND) || (r_state == S_WAIT_IDLE)) && (r_to_cnt == TO_LAST);
    assign w_last_fall = (r_state == S_SEND) && w_fall && (r_bit_idx == 4'd10);
    assign w_line_idle = r_clk_filt & r_data_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (w_accept) w_state_nxt = S_INHIBIT;
            S_INHIBIT:   if (w_inh_end) w_state_nxt = S_RTS;
            S_RTS:       if (w_rts_end) w_state_nxt = S_SEND;
            S_SEND:      if (w_to_hit) w_state_nxt = S_DONE;
                         else if (w_last_fall) w_state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_to_hit || w_line_idle) w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_RTS);
        bus.ps2_data_oe = (r_state == S_RTS) || ((r_state == S_SEND) && r_data_bit);
        bus.busy        = (r_state != S_IDLE);
        bus.rx_inhibit  = (r_state != S_IDLE);
        bus.tx_ready    = (r_state == S_IDLE);
        bus.done        = (r_state == S_DONE);
        bus.ack_ok      = r_ack;
        bus.timeout     = r_to;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_cnt <= '0;
            r_to_cnt    <= '0;
            r_bit_idx   <= '0;
            r_byte      <= '0;
            r_par       <= 1'b0;
            r_data_bit  <= 1'b0;
            r_ack       <= 1'b0;
            r_to        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_byte      <= bus.tx_data;
                    r_par       <= ~^bus.tx_data;
                    r_ack       <= 1'b0;
                    r_to        <= 1'b0;
                    r_phase_cnt <= '0;
                end
                S_INHIBIT: r_phase_cnt <= w_inh_end ? '0 : r_phase_cnt + 1'b1;
                S_RTS: begin
                    r_phase_cnt <= r_phase_cnt + 1'b1;
                    if (w_rts_end) begin
                        r_to_cnt   <= '0;
                        r_bit_idx  <= '0;
                        r_data_bit <= 1'b1;
                    end
                end
                S_SEND, S_WAIT_IDLE: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_to_hit) begin
                        r_to  <= 1'b1;
                        r_ack <= 1'b0;
                    end else if ((r_state == S_SEND) && w_fall) begin
                        // Index counts falls already seen; the line changes on the cycle after each fall.
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx < 4'd8)        r_data_bit <= ~r_byte[r_bit_idx[2:0]];
                        else if (r_bit_idx == 4'd8)  r_data_bit <= ~r_par;
                        else if (r_bit_idx == 4'd9)  r_data_bit <= 1'b0;
                        else                         r_ack      <= ~r_data_sync;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
